// File: rtl/frv_masked_shfrot_pkg.sv
// Shared types and helpers for the sequential masked shift/rotate unit.
package frv_masked_shfrot_pkg;

    typedef enum logic [2:0] {
        OP_SRL = 3'd0,
        OP_SLL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROR = 3'd3,
        OP_ROL = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic int shw_of(input int xlen);
        return $clog2(xlen);
    endfunction

    // Bit offset of share `share` inside a flat NSHARES*XLEN bus.
    function automatic int share_lsb(input int share, input int xlen);
        return share * xlen;
    endfunction

endpackage

// File: rtl/frv_masked_shfrot_seq_if.sv
// Command/result bus of the masked shift/rotate unit; master drives commands.
interface frv_masked_shfrot_seq_if
    import frv_masked_shfrot_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int XLEN    = 32
);
    localparam int SHW = shw_of(XLEN);

    logic                         in_valid;
    logic                         in_ready;
    logic [2:0]                   op;
    logic [SHW-1:0]               shamt;
    logic [NSHARES*XLEN-1:0]      s;
    logic [(NSHARES-1)*XLEN-1:0]  rp;
    logic                         out_valid;
    logic                         out_ready;
    logic [NSHARES*XLEN-1:0]      r;

    modport master (
        output in_valid, op, shamt, s, rp, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, op, shamt, s, rp, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/frv_masked_shfrot_stage.sv
// One barrel stage for one share: shift/rotate by 2^STAGE when enabled,
// filling vacated bits from this share's pad (sign-XOR-pad for SRA).
module frv_masked_shfrot_stage
    import frv_masked_shfrot_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STAGE = 0
) (
    input  logic [XLEN-1:0] data_i,
    input  op_e             op_i,
    input  logic            en_i,
    input  logic [XLEN-1:0] pad_i,
    output logic [XLEN-1:0] data_o
);
    localparam int D = 1 << STAGE;
    localparam logic [XLEN-1:0] LOW_MASK = {XLEN{1'b1}} >> (XLEN - D);

    always_comb begin
        // NOTE: default assignment first so every path drives data_o and no latch is inferred.
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SRL:  data_o = (data_i >> D) | (pad_i << (XLEN - D));
                OP_SLL:  data_o = (data_i << D) | (pad_i & LOW_MASK);
                OP_SRA:  data_o = (data_i >> D)
                                | ((pad_i ^ {XLEN{data_i[XLEN-1]}}) << (XLEN - D));
                OP_ROR:  data_o = (data_i >> D) | (data_i << (XLEN - D));
                OP_ROL:  data_o = (data_i << D) | (data_i >> (XLEN - D));
                default: data_o = data_i;
            endcase
        end
    end
endmodule

// File: rtl/frv_masked_shfrot_seq.sv
// Sequential masked shift/rotate: one shamt bit per cycle over SHW stages,
// constant latency, fresh pads per stage, shares zeroized on hand-off.
module frv_masked_shfrot_seq
    import frv_masked_shfrot_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    frv_masked_shfrot_seq_if.slave  bus
);
    localparam int SHW = shw_of(XLEN);
    localparam logic [SHW-1:0] K_LAST = SHW'(SHW - 1);

    state_e                          state_q, state_d;
    logic [SHW-1:0]                  k_q, k_d;
    logic [SHW-1:0]                  shamt_q, shamt_d;
    op_e                             op_q, op_d;
    logic [NSHARES-1:0][XLEN-1:0]    sh_q, sh_d;
    logic [NSHARES-1:0][XLEN-1:0]    pad;
    logic [NSHARES-1:0][XLEN-1:0]    shifted;
    logic [NSHARES-1:0][SHW-1:0][XLEN-1:0] stage_out;

    // The last pad is the XOR of all rp words, so the pads cancel when unmasked.
    always_comb begin
        pad = '0;
        for (int i = 0; i < NSHARES - 1; i++) begin
            pad[i]         = bus.rp[share_lsb(i, XLEN) +: XLEN];
            pad[NSHARES-1] = pad[NSHARES-1] ^ bus.rp[share_lsb(i, XLEN) +: XLEN];
        end
    end

    for (genvar i = 0; i < NSHARES; i++) begin : g_share
        for (genvar j = 0; j < SHW; j++) begin : g_stage
            frv_masked_shfrot_stage #(
                .XLEN  (XLEN),
                .STAGE (j)
            ) u_stage (
                .data_i (sh_q[i]),
                .op_i   (op_q),
                .en_i   (shamt_q[j]),
                .pad_i  (pad[i]),
                .data_o (stage_out[i][j])
            );
        end
    end

    always_comb begin
        shifted = sh_q;
        for (int j = 0; j < SHW; j++) begin
            if (k_q == SHW'(j)) begin
                for (int i = 0; i < NSHARES; i++) shifted[i] = stage_out[i][j];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        shamt_d       = shamt_q;
        op_d          = op_q;
        sh_d          = sh_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    sh_d    = bus.s;
                    op_d    = op_e'(bus.op);
                    shamt_d = bus.shamt;
                    k_d     = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sh_d = shifted;
                if (k_q == K_LAST) state_d = ST_DONE;
                else               k_d     = k_q + SHW'(1);
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    sh_d    = '0;
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.r = sh_q;

    always_ff @(posedge clk) begin
        // NOTE: share registers are reset too: an aborted command must leave no share material behind.
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            shamt_q <= '0;
            op_q    <= OP_SRL;
            sh_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            k_q     <= k_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
        end
    end
endmodule
